// File: rtl/circular_window_buffer_if.sv
// ---------------------------------------------------------------------------
// circular_window_buffer_if
// Bundles the push and pop handshakes of the circular window buffer so that
// producer, consumer and buffer share one connection.
//   master : drives wen/din/ren, observes wready/rvalid/dout/count/full/empty
//   slave  : the buffer itself, the mirror image of master
// ---------------------------------------------------------------------------
interface circular_window_buffer_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int PAR_WRITE  = 2,
   parameter int PAR_READ   = 3
);
   logic                             wen;
   logic                             wready;
   logic [PAR_WRITE*DATA_WIDTH-1:0]  din;
   logic                             ren;
   logic                             rvalid;
   logic [PAR_READ*DATA_WIDTH-1:0]   dout;
   logic [ADDR_WIDTH:0]              count;
   logic                             full;
   logic                             empty;

   modport master (
      output wen, din, ren,
      input  wready, rvalid, dout, count, full, empty
   );

   modport slave (
      input  wen, din, ren,
      output wready, rvalid, dout, count, full, empty
   );
endinterface

// File: rtl/circular_window_buffer.sv
// ---------------------------------------------------------------------------
// circular_window_buffer
// Circular buffer of 2**ADDR_WIDTH words. Each accepted push writes PAR_WRITE
// consecutive words; the consumer always sees a window of PAR_READ
// consecutive words starting at the read pointer, and each accepted pop
// advances that window by READ_STRIDE words, so overlapping words are reused.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset (pointers and count only)
//   clr  : synchronous clear, present only when CIRC_BUFFER_CLEAR_EN is
//          defined; empties the buffer without touching memory
//   bus  : slave side of circular_window_buffer_if
//          (wen/wready/din push, ren/rvalid/dout pop, count/full/empty status)
// Optional feature macro: CIRC_BUFFER_CLEAR_EN
// ---------------------------------------------------------------------------
module circular_window_buffer #(
   parameter int ADDR_WIDTH  = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int PAR_WRITE   = 2,
   parameter int PAR_READ    = 3,
   parameter int READ_STRIDE = 1
) (
   input  logic clk,
   input  logic rst,
`ifdef CIRC_BUFFER_CLEAR_EN
   input  logic clr,
`endif
   circular_window_buffer_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 2;

   localparam logic [CW-1:0] DEPTH_W  = CW'(DEPTH);
   localparam logic [CW-1:0] PW_W     = CW'(PAR_WRITE);
   localparam logic [CW-1:0] PR_W     = CW'(PAR_READ);
   localparam logic [CW-1:0] STRIDE_W = CW'(READ_STRIDE);

   // Pointer increments wrap naturally because DEPTH is a power of two.
   localparam logic [ADDR_WIDTH-1:0] W_INC = ADDR_WIDTH'(PAR_WRITE % DEPTH);
   localparam logic [ADDR_WIDTH-1:0] R_INC = ADDR_WIDTH'(READ_STRIDE % DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;

   logic [CW-1:0] countExt;
   logic          clrActive;
   logic          pushAcc;
   logic          popAcc;

`ifdef CIRC_BUFFER_CLEAR_EN
   assign clrActive = clr;
`else
   assign clrActive = 1'b0;
`endif

   assign countExt = {1'b0, count_q};

   // Status flags depend only on the registered count, so there is no
   // combinational path from the request inputs to any output.
   assign bus.wready = (DEPTH_W - countExt) >= PW_W;
   assign bus.rvalid = countExt >= PR_W;
   assign bus.full   = (countExt == DEPTH_W);
   assign bus.empty  = (count_q == '0);
   assign bus.count  = count_q;

   // Both acceptances use the pre-edge count, so a same-cycle pop never makes
   // room for a push and a same-cycle push never validates a pop. A clear
   // suppresses both so that nothing is written while emptying.
   assign pushAcc = bus.wen && bus.wready && !clrActive;
   assign popAcc  = bus.ren && bus.rvalid && !clrActive;

   // Next-state pointers and occupancy. The count is formed one bit wider
   // than stored so the add and subtract cannot wrap before truncation.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clrActive) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (pushAcc) wptr_d = wptr_q + W_INC;
         if (popAcc)  rptr_d = rptr_q + R_INC;
         count_d = (ADDR_WIDTH+1)'(countExt
                                   + (pushAcc ? PW_W : '0)
                                   - (popAcc ? STRIDE_W : '0));
      end
   end

   // Pointer and count registers; reset clears them immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately not reset; an accepted push scatters its words
   // into consecutive slots, wrapping past the last index back to zero.
   always_ff @(posedge clk) begin
      if (pushAcc) begin
         for (int i = 0; i < PAR_WRITE; i++) begin
            mem_q[wptr_q + ADDR_WIDTH'(i)] <= bus.din[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // The read window is a pure function of the read pointer and memory;
   // it may straddle the last index and is meaningless while rvalid is low.
   always_comb begin
      bus.dout = '0;
      for (int j = 0; j < PAR_READ; j++) begin
         bus.dout[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rptr_q + ADDR_WIDTH'(j)];
      end
   end

endmodule

// File: tb/tb_circular_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_circular_window_buffer
// Self-checking bench for circular_window_buffer with ADDR_WIDTH=4,
// DATA_WIDTH=8, PAR_WRITE=2, PAR_READ=3, READ_STRIDE=1. The reference model
// is a queue of the words currently held, oldest first; the window is simply
// its first three entries.
// ---------------------------------------------------------------------------
module tb_circular_window_buffer;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int PW = 2;
   localparam int PR = 3;
   localparam int RS = 1;
   localparam int DEPTH = 16;

   logic clk;
   logic rst;
`ifdef CIRC_BUFFER_CLEAR_EN
   logic clr;
`endif

   int assertCount;
   int failCount;

   logic [DW-1:0] modelQ [$];

   circular_window_buffer_if #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PAR_WRITE(PW), .PAR_READ(PR)
   ) bus ();

   circular_window_buffer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PAR_WRITE(PW),
      .PAR_READ(PR), .READ_STRIDE(RS)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef CIRC_BUFFER_CLEAR_EN
      .clr(clr),
`endif
      .bus(bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Compares every status output, and the window whenever the model says
   // it is valid, against the word queue.
   task automatic checkAgainstModel(input string tag);
      int n;
      logic [31:0] expWin;
      n = modelQ.size();
      checkOutput({tag, " count"},  32'(bus.count),  32'(n));
      checkOutput({tag, " rvalid"}, 32'(bus.rvalid), 32'(n >= PR));
      checkOutput({tag, " wready"}, 32'(bus.wready), 32'((DEPTH - n) >= PW));
      checkOutput({tag, " full"},   32'(bus.full),   32'(n == DEPTH));
      checkOutput({tag, " empty"},  32'(bus.empty),  32'(n == 0));
      if (n >= PR) begin
         expWin = {8'h00, modelQ[2], modelQ[1], modelQ[0]};
         checkOutput({tag, " dout"}, 32'(bus.dout), expWin);
      end
   endtask

   // One clock cycle of traffic; acceptance is decided from the model's
   // occupancy before the edge, then the queue is updated and compared.
   task automatic applyStimulus(input logic w, input logic [15:0] d,
                                input logic r, input string tag);
      bit pushOk;
      bit popOk;
      bus.wen = w;
      bus.din = d;
      bus.ren = r;
      pushOk = w && ((DEPTH - modelQ.size()) >= PW);
      popOk  = r && (modelQ.size() >= PR);
      @(posedge clk);
      if (popOk) begin
         for (int k = 0; k < RS; k++) void'(modelQ.pop_front());
      end
      if (pushOk) begin
         modelQ.push_back(d[7:0]);
         modelQ.push_back(d[15:8]);
      end
      #1;
      bus.wen = 1'b0;
      bus.ren = 1'b0;
      checkAgainstModel(tag);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear at once.
   task automatic pulseReset(input string tag);
      @(negedge clk);
      #1;
      rst = 1'b1;
      modelQ.delete();
      #1;
      checkAgainstModel(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst     = 1'b1;
      bus.wen = 1'b0;
      bus.ren = 1'b0;
      bus.din = '0;
`ifdef CIRC_BUFFER_CLEAR_EN
      clr = 1'b0;
`endif
      #2;
      checkAgainstModel("reset");
      checkOutput("reset wready", 32'(bus.wready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Window fill and a single sliding pop
      applyStimulus(1'b1, 16'h1110, 1'b0, "fill1");
      checkOutput("fill1 rvalid", 32'(bus.rvalid), 32'd0);
      applyStimulus(1'b1, 16'h1312, 1'b0, "fill2");
      checkOutput("fill2 dout", 32'(bus.dout), 32'h00121110);
      applyStimulus(1'b0, 16'h0000, 1'b1, "pop1");
      checkOutput("pop1 dout", 32'(bus.dout), 32'h00131211);
      checkOutput("pop1 count", 32'(bus.count), 32'd3);

      // Reset in the middle of traffic at count 7
      applyStimulus(1'b1, 16'h1514, 1'b0, "pre7a");
      applyStimulus(1'b1, 16'h1716, 1'b0, "pre7b");
      checkOutput("pre-reset count", 32'(bus.count), 32'd7);
      pulseReset("midreset");

      // Fill to full, then an overflow push that must be dropped
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 16'(((2*i+1) << 8) | (2*i) | 16'h2020), 1'b0, "fullfill");
      checkOutput("full flag", 32'(bus.full), 32'd1);
      applyStimulus(1'b1, 16'hFFFF, 1'b0, "overflow");
      checkOutput("overflow count", 32'(bus.count), 32'd16);

      // Drain down to 2 words, then an underflowing pop
      for (int i = 0; i < 14; i++)
         applyStimulus(1'b0, 16'h0000, 1'b1, "drain");
      applyStimulus(1'b0, 16'h0000, 1'b1, "underflow");
      checkOutput("underflow count", 32'(bus.count), 32'd2);

      // Read window straddling the wrap point with a simultaneous push/pop:
      // rptr now 14 and wptr 0, so the pop is rejected on pre-edge count 2.
      applyStimulus(1'b1, 16'hB1B0, 1'b1, "wrapsim");
      checkOutput("wrapsim count", 32'(bus.count), 32'd4);
      applyStimulus(1'b0, 16'h0000, 1'b1, "wrappop");
      checkOutput("wrappop dout", 32'(bus.dout), 32'h00B1B02F);

`ifdef CIRC_BUFFER_CLEAR_EN
      // Clear beats a concurrent push and pop at count 9
      pulseReset("preclear");
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 16'(16'h4040 + i), 1'b0, "clrfill");
      applyStimulus(1'b0, 16'h0000, 1'b1, "clrpop");
      checkOutput("preclear count", 32'(bus.count), 32'd9);
      clr     = 1'b1;
      bus.wen = 1'b1;
      bus.ren = 1'b1;
      bus.din = 16'hEEEE;
      @(posedge clk);
      modelQ.delete();
      #1;
      clr     = 1'b0;
      bus.wen = 1'b0;
      bus.ren = 1'b0;
      checkAgainstModel("clear");
`endif

      // Randomised traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            pulseReset("randreset");
         end else begin
            applyStimulus(1'($urandom_range(0, 99) < 55), 16'($urandom),
                          1'($urandom_range(0, 99) < 50), "random");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
